lcd_frame_sequencer: RTL and testbench

//  Sequences one full-screen write to the ST7735 panel once its init is complete.
//  On FRAME_START it emits CASET/RASET window commands, RAMWR, then WIDTH*HEIGHT RGB565 pixels.

---
 rtl/lcd_frame_sequencer_pkg.sv | 51 +++++
 rtl/lcd_tx_slot.sv | 71 +++++++
 rtl/lcd_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_frame_sequencer_pkg
//  Purpose  : Shared ST7735 definitions. These are the command opcodes,
//             the sequencer state encodings, the RGB565 pixel width and a
//             helper that returns one byte of a CASET/RASET window
//             argument. The ST7735 driver and the pixel generators use the
//             same constants.
//  Revision : 1.0 - initial release
// ============================================================================
package lcd_frame_sequencer_pkg;

    // ST7735 command opcodes
    localparam logic [7:0] c_cmd_caset = 8'h2A;
    localparam logic [7:0] c_cmd_raset = 8'h2B;
    localparam logic [7:0] c_cmd_ramwr = 8'h2C;

    // One RGB565 pixel is sent as two bytes, high byte first
    localparam int c_rgb565_w = 16;

    // Sequencer state encoding
    localparam int         c_st_w      = 3;
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_caset  = 3'd1;
    localparam logic [2:0] c_st_raset  = 3'd2;
    localparam logic [2:0] c_st_ramwr  = 3'd3;
    localparam logic [2:0] c_st_pix_hi = 3'd4;
    localparam logic [2:0] c_st_pix_lo = 3'd5;
    localparam logic [2:0] c_st_done   = 3'd6;

    // CASET/RASET byte index: 0 = opcode, 1..4 = 00 first 00 last
    localparam logic [2:0] c_arg_last  = 3'd4;

    // Window argument byte for index 1..4.
    // The address high bytes are always zero for this panel.
    function automatic logic [7:0] window_arg(
        input logic [2:0] idx,
        input logic [7:0] first,
        input logic [7:0] last
    );
        logic [7:0] b;
        case (idx)
            3'd2:    b = first;
            3'd4:    b = last;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_tx_slot.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_tx_slot
//  Purpose  : Single-entry registered byte slot in front of the SPI byte
//             transmitter. The slot can load whenever it is empty or its
//             byte is being consumed this cycle, so bytes can stream at one
//             per cycle. While the transmitter stalls, the contents stay
//             stable.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             i_flush         - drop any held byte (frame abort)
//             i_load          - request to load i_data/i_dc
//             i_data, i_dc    - byte and data/command flag to load
//             i_tx_ready      - transmitter accepts the held byte
//             o_tx_data/dc    - held byte and flag
//             o_tx_valid      - slot holds a byte
//             o_loadable      - a load this cycle is accepted
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_tx_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_flush,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_dc,
    input  logic       i_tx_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_dc,
    output logic       o_tx_valid,
    output logic       o_loadable
);

    logic [7:0] data_q, data_d;
    logic       dc_q, dc_d;
    logic       valid_q, valid_d;

    assign o_loadable = !valid_q || i_tx_ready;

    always_comb begin
        data_d  = data_q;
        dc_d    = dc_q;
        valid_d = valid_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_load && o_loadable) begin
            data_d  = i_data;
            dc_d    = i_dc;
            valid_d = 1'b1;
        end else if (i_tx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 8'h00;
            dc_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            dc_q    <= dc_d;
            valid_q <= valid_d;
        end
    end

    assign o_tx_data  = data_q;
    assign o_tx_dc    = dc_q;
    assign o_tx_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_frame_sequencer
//  Purpose  : Writes one full ST7735 frame. After FRAME_START it sends a
//             CASET/RASET window, then RAMWR, then WIDTH*HEIGHT RGB565
//             pixels taken from a valid/ready pixel source. The pixels go
//             out MSB byte first through a registered byte slot.
//  Ports    : SYSTEM_CLK, RST_N          - clock, async active-low reset
//             LCD_READY                  - panel init done (low aborts)
//             FRAME_START                - 1-cycle frame request
//             PX_DATA/PX_VALID/PX_READY  - upstream pixel handshake
//             TX_DATA/TX_DC/TX_VALID     - byte to SPI transmitter
//             TX_READY                   - transmitter consumes byte
//             BUSY                       - frame in progress
//             FRAME_DONE                 - 1-cycle pulse at frame end
//             FRAME_CNT                  - completed frame count (optional)
//  Config   : define LCD_FRAME_CNT_EN to add FRAME_CNT[15:0].
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_frame_sequencer
    import lcd_frame_sequencer_pkg::*;
#(
    parameter int WIDTH    = 128,
    parameter int HEIGHT   = 160,
    parameter int X_OFFSET = 0,
    parameter int Y_OFFSET = 0
) (
    input  logic                  SYSTEM_CLK,
    input  logic                  RST_N,
    input  logic                  LCD_READY,
    input  logic                  FRAME_START,
    input  logic [c_rgb565_w-1:0] PX_DATA,
    input  logic                  PX_VALID,
    output logic                  PX_READY,
    output logic [7:0]            TX_DATA,
    output logic                  TX_DC,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  BUSY,
`ifdef LCD_FRAME_CNT_EN
    output logic [15:0]           FRAME_CNT,
`endif
    output logic                  FRAME_DONE
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [CNT_W-1:0] c_px_last = CNT_W'(TOTAL - 1);
    localparam logic [7:0]       c_xs      = 8'(X_OFFSET);
    localparam logic [7:0]       c_xe      = 8'(X_OFFSET + WIDTH - 1);
    localparam logic [7:0]       c_ys      = 8'(Y_OFFSET);
    localparam logic [7:0]       c_ye      = 8'(Y_OFFSET + HEIGHT - 1);

    logic [c_st_w-1:0] state_q, state_d;
    logic [2:0]        arg_idx_q, arg_idx_d;
    logic [CNT_W-1:0]  px_cnt_q, px_cnt_d;
    logic [7:0]        lo_byte_q, lo_byte_d;
    logic              frame_done_q, frame_done_d;

    logic       w_abort;
    logic       w_loadable;
    logic       w_load;
    logic [7:0] w_load_data;
    logic       w_load_dc;
    logic       w_px_ready;

    // Panel dropped out of ready mid-frame: the frame is abandoned
    assign w_abort = (state_q != c_st_idle) && !LCD_READY;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge SYSTEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= c_st_idle;
            arg_idx_q    <= 3'd0;
            px_cnt_q     <= '0;
            lo_byte_q    <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            arg_idx_q    <= arg_idx_d;
            px_cnt_q     <= px_cnt_d;
            lo_byte_q    <= lo_byte_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        arg_idx_d = arg_idx_q;
        px_cnt_d  = px_cnt_q;
        lo_byte_d = lo_byte_q;
        if (w_abort) begin
            state_d   = c_st_idle;
            arg_idx_d = 3'd0;
            px_cnt_d  = '0;
        end else begin
            case (state_q)
                c_st_idle: begin
                    if (FRAME_START && LCD_READY) begin
                        state_d   = c_st_caset;
                        arg_idx_d = 3'd0;
                        px_cnt_d  = '0;
                    end
                end
                c_st_caset, c_st_raset: begin
                    if (w_loadable) begin
                        if (arg_idx_q == c_arg_last) begin
                            arg_idx_d = 3'd0;
                            state_d   = (state_q == c_st_caset) ? c_st_raset : c_st_ramwr;
                        end else begin
                            arg_idx_d = arg_idx_q + 3'd1;
                        end
                    end
                end
                c_st_ramwr: begin
                    if (w_loadable) begin
                        state_d = c_st_pix_hi;
                    end
                end
                c_st_pix_hi: begin
                    // The low byte is held here so the source can move on
                    // as soon as the high byte is taken.
                    if (w_loadable && PX_VALID) begin
                        lo_byte_d = PX_DATA[7:0];
                        state_d   = c_st_pix_lo;
                    end
                end
                c_st_pix_lo: begin
                    if (w_loadable) begin
                        if (px_cnt_q == c_px_last) begin
                            px_cnt_d = '0;
                            state_d  = c_st_done;
                        end else begin
                            px_cnt_d = px_cnt_q + CNT_W'(1);
                            state_d  = c_st_pix_hi;
                        end
                    end
                end
                c_st_done: begin
                    // Finish once the last byte is consumed or being consumed
                    if (w_loadable) begin
                        state_d = c_st_idle;
                    end
                end
                default: begin
                    state_d = c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_load       = 1'b0;
        w_load_data  = 8'h00;
        w_load_dc    = 1'b0;
        w_px_ready   = 1'b0;
        frame_done_d = 1'b0;
        if (!w_abort) begin
            case (state_q)
                c_st_caset: begin
                    w_load      = w_loadable;
                    w_load_data = (arg_idx_q == 3'd0) ? c_cmd_caset
                                                      : window_arg(arg_idx_q, c_xs, c_xe);
                    w_load_dc   = (arg_idx_q != 3'd0);
                end
                c_st_raset: begin
                    w_load      = w_loadable;
                    w_load_data = (arg_idx_q == 3'd0) ? c_cmd_raset
                                                      : window_arg(arg_idx_q, c_ys, c_ye);
                    w_load_dc   = (arg_idx_q != 3'd0);
                end
                c_st_ramwr: begin
                    w_load      = w_loadable;
                    w_load_data = c_cmd_ramwr;
                    w_load_dc   = 1'b0;
                end
                c_st_pix_hi: begin
                    w_px_ready  = w_loadable;
                    w_load      = w_loadable && PX_VALID;
                    w_load_data = PX_DATA[15:8];
                    w_load_dc   = 1'b1;
                end
                c_st_pix_lo: begin
                    w_load      = w_loadable;
                    w_load_data = lo_byte_q;
                    w_load_dc   = 1'b1;
                end
                c_st_done: begin
                    frame_done_d = w_loadable;
                end
                default: begin
                    w_load = 1'b0;
                end
            endcase
        end
    end

    lcd_tx_slot u_tx_slot (
        .clk        (SYSTEM_CLK),
        .rst_n      (RST_N),
        .i_flush    (w_abort),
        .i_load     (w_load),
        .i_data     (w_load_data),
        .i_dc       (w_load_dc),
        .i_tx_ready (TX_READY),
        .o_tx_data  (TX_DATA),
        .o_tx_dc    (TX_DC),
        .o_tx_valid (TX_VALID),
        .o_loadable (w_loadable)
    );

    assign PX_READY   = w_px_ready;
    assign BUSY       = (state_q != c_st_idle);
    assign FRAME_DONE = frame_done_q;

`ifdef LCD_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counts only completed frames; wraps naturally at 16 bits
    always_comb begin
        frame_cnt_d = frame_done_d ? (frame_cnt_q + 16'd1) : frame_cnt_q;
    end

    always_ff @(posedge SYSTEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt_q <= 16'h0000;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign FRAME_CNT = frame_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_frame_sequencer
//  Purpose  : Directed self-checking bench for lcd_frame_sequencer. It uses
//             a 2x2 instance for the full-frame scenarios and a 128x160
//             instance with offsets 2/1 for the window argument check.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 2x2 instance ----------------
    logic        rst_n, lcd_ready, frame_start, px_valid;
    logic        tx_ready = 1'b1;
    logic [15:0] px_data;
    logic        px_ready, tx_dc, tx_valid, busy, frame_done;
    logic [7:0]  tx_data;
`ifdef LCD_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] frame_cnt2;
`endif

    // ---------------- 128x160 offset instance ----------------
    logic        lcd_ready2, frame_start2;
    logic        tx_ready2 = 1'b1;
    logic        px_valid2 = 1'b0;
    logic [15:0] px_data2  = 16'h0000;
    logic        px_ready2, tx_dc2, tx_valid2, busy2, frame_done2;
    logic [7:0]  tx_data2;

    lcd_frame_sequencer #(.WIDTH(2), .HEIGHT(2), .X_OFFSET(0), .Y_OFFSET(0)) dut (
        .SYSTEM_CLK (clk),
        .RST_N      (rst_n),
        .LCD_READY  (lcd_ready),
        .FRAME_START(frame_start),
        .PX_DATA    (px_data),
        .PX_VALID   (px_valid),
        .PX_READY   (px_ready),
        .TX_DATA    (tx_data),
        .TX_DC      (tx_dc),
        .TX_VALID   (tx_valid),
        .TX_READY   (tx_ready),
        .BUSY       (busy),
`ifdef LCD_FRAME_CNT_EN
        .FRAME_CNT  (frame_cnt),
`endif
        .FRAME_DONE (frame_done)
    );

    lcd_frame_sequencer #(.WIDTH(128), .HEIGHT(160), .X_OFFSET(2), .Y_OFFSET(1)) dut_off (
        .SYSTEM_CLK (clk),
        .RST_N      (rst_n),
        .LCD_READY  (lcd_ready2),
        .FRAME_START(frame_start2),
        .PX_DATA    (px_data2),
        .PX_VALID   (px_valid2),
        .PX_READY   (px_ready2),
        .TX_DATA    (tx_data2),
        .TX_DC      (tx_dc2),
        .TX_VALID   (tx_valid2),
        .TX_READY   (tx_ready2),
        .BUSY       (busy2),
`ifdef LCD_FRAME_CNT_EN
        .FRAME_CNT  (frame_cnt2),
`endif
        .FRAME_DONE (frame_done2)
    );

    int tests  = 0;
    int errors = 0;

    // ---------------- monitors (sample on negedge) ----------------
    logic [8:0] cap  [$];
    logic [8:0] cap2 [$];
    int         fd_cnt     = 0;
    int         stall_err  = 0;
    int         px_idx     = 0;
    int         px_base    = 0;
    logic       px_take    = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_byte  = 9'h000;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) cap.push_back({tx_dc, tx_data});
        if (tx_valid2 && tx_ready2) cap2.push_back({tx_dc2, tx_data2});
        if (frame_done) fd_cnt++;
        if (prev_stall && (!tx_valid || ({tx_dc, tx_data} !== prev_byte))) stall_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = {tx_dc, tx_data};
        px_take    = px_valid && px_ready;
    end

    // Pixel source: the k-th pixel of a frame is F800+k
    always @(posedge clk) begin
        #1;
        if (px_take) px_idx++;
    end
    assign px_data = 16'hF800 + 16'(px_idx - px_base);

    // Transmitter back-pressure: always ready, or a fixed stall pattern
    int          rdy_mode = 0;
    int          rdy_pos  = 0;
    logic [15:0] rdy_pat  = 16'b1011_0010_0110_1101;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            tx_ready = rdy_pat[rdy_pos % 16];
            rdy_pos++;
        end else begin
            tx_ready = 1'b1;
        end
    end

    logic [8:0] exp_basic [19];
    logic [8:0] exp_off   [11];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        for (int i = 0; i < 400; i++) begin
            if (fd_cnt > base) break;
            tick();
        end
        ok = (fd_cnt > base);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; lcd_ready = 1'b0; frame_start = 1'b0; px_valid = 1'b0;
        lcd_ready2 = 1'b0; frame_start2 = 1'b0;
        repeat (3) tick();
        tests++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        tests++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        tests++; if (tx_dc !== 1'b0) begin errors++; $display("FAIL reset_tx_dc: got %b want 0", tx_dc); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        tests++; if (px_ready !== 1'b0) begin errors++; $display("FAIL reset_px_ready: got %b want 0", px_ready); end
`ifdef LCD_FRAME_CNT_EN
        tests++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
`endif
        rst_n = 1'b1; lcd_ready = 1'b1; lcd_ready2 = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic_frame();
        int base; int fd0; bit ok; logic [8:0] got;
        base = cap.size(); fd0 = fd_cnt; px_base = px_idx; px_valid = 1'b1; rdy_mode = 0;
        pulse_start();
        tests++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b want 1", busy); end
        tests++; if (px_ready !== 1'b0) begin errors++; $display("FAIL basic_px_ready_caset: got %b want 0", px_ready); end
        wait_done(fd0, ok);
        tests++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no FRAME_DONE want one"); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        repeat (4) tick();
        tests++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", fd_cnt - fd0); end
        tests++; if (cap.size() - base != 19) begin errors++; $display("FAIL basic_len: got %0d want 19", cap.size() - base); end
        for (int i = 0; i < 19; i++) begin
            got = (base + i < cap.size()) ? cap[base + i] : 9'h1FF;
            tests++; if (got !== exp_basic[i]) begin errors++; $display("FAIL basic_byte%0d: got dc/data %h want %h", i, got, exp_basic[i]); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_offsets();
        int base; logic [8:0] got;
        base = cap2.size();
        frame_start2 = 1'b1; tick(); frame_start2 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cap2.size() - base >= 11) break;
            tick();
        end
        lcd_ready2 = 1'b0;
        tick();
        tests++; if (busy2 !== 1'b0) begin errors++; $display("FAIL off_abort_busy: got %b want 0", busy2); end
        for (int i = 0; i < 11; i++) begin
            got = (base + i < cap2.size()) ? cap2[base + i] : 9'h1FF;
            tests++; if (got !== exp_off[i]) begin errors++; $display("FAIL off_byte%0d: got dc/data %h want %h", i, got, exp_off[i]); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_tx_stall();
        int base; int fd0; int se0; bit ok; logic [8:0] got;
        base = cap.size(); fd0 = fd_cnt; se0 = stall_err; px_base = px_idx; px_valid = 1'b1; rdy_mode = 1;
        pulse_start();
        wait_done(fd0, ok);
        tick(); tick();
        rdy_mode = 0;
        tick();
        tests++; if (!ok) begin errors++; $display("FAIL stall_timeout: got no FRAME_DONE want one"); end
        tests++; if (stall_err != se0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stall_err - se0); end
        tests++; if (cap.size() - base != 19) begin errors++; $display("FAIL stall_len: got %0d want 19", cap.size() - base); end
        for (int i = 0; i < 19; i++) begin
            got = (base + i < cap.size()) ? cap[base + i] : 9'h1FF;
            tests++; if (got !== exp_basic[i]) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, got, exp_basic[i]); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_px_stall();
        int base; int fd0; bit ok; logic [8:0] got;
        base = cap.size(); fd0 = fd_cnt; px_base = px_idx; px_valid = 1'b1; rdy_mode = 0;
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            if (px_idx - px_base >= 2) break;
            tick();
        end
        px_valid = 1'b0;
        repeat (10) tick();
        tests++; if (px_idx - px_base != 2) begin errors++; $display("FAIL pxs_accepted: got %0d want 2", px_idx - px_base); end
        tests++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pxs_tx_valid: got %b want 0", tx_valid); end
        tests++; if (px_ready !== 1'b1) begin errors++; $display("FAIL pxs_px_ready: got %b want 1", px_ready); end
        tests++; if (busy !== 1'b1) begin errors++; $display("FAIL pxs_busy: got %b want 1", busy); end
        px_valid = 1'b1;
        wait_done(fd0, ok);
        tick();
        tests++; if (!ok) begin errors++; $display("FAIL pxs_timeout: got no FRAME_DONE want one"); end
        tests++; if (cap.size() - base != 19) begin errors++; $display("FAIL pxs_len: got %0d want 19", cap.size() - base); end
        for (int i = 0; i < 19; i++) begin
            got = (base + i < cap.size()) ? cap[base + i] : 9'h1FF;
            tests++; if (got !== exp_basic[i]) begin errors++; $display("FAIL pxs_byte%0d: got %h want %h", i, got, exp_basic[i]); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_abort();
        int base; int fd0; int n_abort; bit ok; logic [8:0] got;
        fd0 = fd_cnt; px_base = px_idx; px_valid = 1'b1; rdy_mode = 0;
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            if (px_idx - px_base >= 3) break;
            tick();
        end
        lcd_ready = 1'b0;
        tick();
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        tests++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_valid: got %b want 0", tx_valid); end
        tests++; if (px_ready !== 1'b0) begin errors++; $display("FAIL abort_px_ready: got %b want 0", px_ready); end
        n_abort = cap.size();
        tick();
        pulse_start();
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_ignored: got busy %b want 0", busy); end
        repeat (5) tick();
        tests++; if (fd_cnt != fd0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", fd_cnt - fd0); end
        tests++; if (cap.size() != n_abort) begin errors++; $display("FAIL abort_no_bytes: got %0d bytes want 0", cap.size() - n_abort); end
        lcd_ready = 1'b1;
        tick();
        base = cap.size(); px_base = px_idx;
        pulse_start();
        wait_done(fd0, ok);
        tick();
        tests++; if (!ok) begin errors++; $display("FAIL abort_restart_timeout: got no FRAME_DONE want one"); end
        for (int i = 0; i < 19; i++) begin
            got = (base + i < cap.size()) ? cap[base + i] : 9'h1FF;
            tests++; if (got !== exp_basic[i]) begin errors++; $display("FAIL abort_restart_byte%0d: got %h want %h", i, got, exp_basic[i]); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int base; int fd0; bit ok;
        base = cap.size(); fd0 = fd_cnt; px_base = px_idx; px_valid = 1'b1; rdy_mode = 0;
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_done(fd0, ok);
        repeat (20) tick();
        tests++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got no FRAME_DONE want one"); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", busy); end
        tests++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", fd_cnt - fd0); end
        tests++; if (cap.size() - base != 19) begin errors++; $display("FAIL b2b_len: got %0d want 19", cap.size() - base); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        px_base = px_idx; px_valid = 1'b1; rdy_mode = 0;
        pulse_start();
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        tests++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid: got %b want 0", tx_valid); end
        tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef LCD_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int fd0; bit ok;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        tests++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", frame_cnt); end
        px_base = px_idx; px_valid = 1'b1; rdy_mode = 0;
        pulse_start();
        repeat (5) tick();
        lcd_ready = 1'b0; tick(); lcd_ready = 1'b1; tick();
        for (int f = 0; f < 2; f++) begin
            fd0 = fd_cnt; px_base = px_idx;
            pulse_start();
            wait_done(fd0, ok);
            tick();
            tests++; if (!ok) begin errors++; $display("FAIL cnt_frame%0d_timeout: got no FRAME_DONE want one", f); end
        end
        tests++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL cnt_value: got %0d want 2", frame_cnt); end
    endtask
`endif

    // ------------------------------------------------------------------
    initial begin
        exp_basic = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
                      9'h02B, 9'h100, 9'h100, 9'h100, 9'h101,
                      9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h101,
                      9'h1F8, 9'h102, 9'h1F8, 9'h103};
        exp_off   = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h181,
                      9'h02B, 9'h100, 9'h101, 9'h100, 9'h1A0,
                      9'h02C};
        test_reset();
        test_basic_frame();
        test_offsets();
        test_tx_stall();
        test_px_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef LCD_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
